// File: rtl/switch_mcu_pkg.sv
// Shared definitions for the switch MCU execution units: opcodes, defaults and
// the writeback entry layout.
package switch_mcu_pkg;

  localparam int unsigned WADDR_W           = 5;
  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam int unsigned PC_OFFSET_DEFAULT = 4;

  localparam logic [1:0] OP_LUI   = 2'd0;
  localparam logic [1:0] OP_AUIPC = 2'd1;
  localparam logic [1:0] OP_JAL   = 2'd2;
  localparam logic [1:0] OP_JALR  = 2'd3;

  // Writeback entry at the default width; wider cores build the same layout locally.
  typedef struct packed {
    logic [WADDR_W-1:0]      waddr;
    logic [XLEN_DEFAULT-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/switch_mcu_wb_fifo.sv
// Writeback FIFO: DEPTH entries, wrapping pointers, occupancy count and full flag.
// Pushes while full and pops while empty are ignored.
module switch_mcu_wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         in_clk,
  input  logic                         in_rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic [WIDTH-1:0]             head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge in_clk) begin
    if (in_rst && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/switch_mcu_alu_upper.sv
// Upper-immediate / jump unit: LUI, AUIPC, JAL, JALR with a buffered writeback
// port and registered redirect / misalignment pulses.
module switch_mcu_alu_upper
  import switch_mcu_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned ISSUE_CYCLE = 1,
  parameter int unsigned PC_OFFSET   = PC_OFFSET_DEFAULT
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic [3:0]         in_cycle_cnt,
  input  logic               in_en,
  input  logic [1:0]         in_op,
  input  logic [XLEN-1:0]    in_pc_reg,
  input  logic [19:0]        in_imm_type_u,
  input  logic [20:0]        in_imm_type_j,
  input  logic [11:0]        in_imm_type_i,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [4:0]         in_rd,
  input  logic               in_wb_ready,
  output logic [4:0]         out_waddr,
  output logic               out_wen,
  output logic [XLEN-1:0]    out_wdata,
  output logic               out_jump_en,
  output logic [XLEN-1:0]    out_jump_addr,
  output logic               out_misalign,
  output logic               out_busy
);

  localparam int unsigned ENTRY_W = WADDR_W + XLEN;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [XLEN-1:0]    wdata;
  } entry_t;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm_u;
  logic [XLEN-1:0]  imm_j;
  logic [XLEN-1:0]  imm_i;
  logic [XLEN-1:0]  result;
  logic [XLEN-1:0]  target;
  logic             is_jump;
  logic             misalign;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic             full;
  entry_t           push_entry;
  entry_t           head_entry;

  logic             jump_en_q;
  logic [XLEN-1:0]  jump_addr_q;
  logic             misalign_q;

  // Operand shaping and per-opcode result / target selection.
  always_comb begin
    pc      = in_pc_reg - XLEN'(PC_OFFSET);
    imm_u   = XLEN'($signed({in_imm_type_u, 12'h000}));
    imm_j   = XLEN'($signed(in_imm_type_j));
    imm_i   = XLEN'($signed(in_imm_type_i));
    result  = pc + XLEN'(4);
    target  = '0;
    is_jump = 1'b0;
    case (in_op)
      OP_LUI:   result = imm_u;
      OP_AUIPC: result = pc + imm_u;
      OP_JAL: begin
        is_jump = 1'b1;
        target  = pc + imm_j;
      end
      OP_JALR: begin
        is_jump = 1'b1;
        target  = (in_rs1_data + imm_i) & ~XLEN'(1);
      end
      default: ;
    endcase
  end

  assign misalign   = is_jump && target[1];
  assign accept     = in_en && (in_cycle_cnt == 4'(ISSUE_CYCLE)) && !full;
  assign push       = accept && (in_rd != '0) && !misalign;
  assign pop        = (count != '0) && in_wb_ready;
  assign push_entry = '{waddr: in_rd, wdata: result};

  switch_mcu_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .full      (full),
    .head      (head_entry)
  );

  // One-cycle redirect and fault pulses, independent of queue occupancy.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      jump_en_q   <= 1'b0;
      jump_addr_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      jump_en_q   <= accept && is_jump && !misalign;
      jump_addr_q <= (accept && is_jump && !misalign) ? target : '0;
      misalign_q  <= accept && misalign;
    end
  end

  assign out_wen       = (count != '0);
  assign out_waddr     = out_wen ? head_entry.waddr : '0;
  assign out_wdata     = out_wen ? head_entry.wdata : '0;
  assign out_busy      = full;
  assign out_jump_en   = jump_en_q;
  assign out_jump_addr = jump_addr_q;
  assign out_misalign  = misalign_q;

endmodule

// File: tb/tb_switch_mcu_alu_upper.sv
// Bench for switch_mcu_alu_upper: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the unit.
module tb_switch_mcu_alu_upper;
  import switch_mcu_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            in_clk = 1'b0;
  logic            in_rst;
  logic [3:0]      in_cycle_cnt;
  logic            in_en;
  logic [1:0]      in_op;
  logic [31:0]     in_pc_reg;
  logic [19:0]     in_imm_type_u;
  logic [20:0]     in_imm_type_j;
  logic [11:0]     in_imm_type_i;
  logic [31:0]     in_rs1_data;
  logic [4:0]      in_rd;
  logic            in_wb_ready;
  logic [4:0]      out_waddr;
  logic            out_wen;
  logic [31:0]     out_wdata;
  logic            out_jump_en;
  logic [31:0]     out_jump_addr;
  logic            out_misalign;
  logic            out_busy;

  logic [4:0]      w64_waddr;
  logic            w64_wen;
  logic [63:0]     w64_wdata;
  logic            w64_jump_en;
  logic [63:0]     w64_jump_addr;
  logic            w64_misalign;
  logic            w64_busy;

  always #5 in_clk = ~in_clk;

  switch_mcu_alu_upper #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_cycle_cnt(in_cycle_cnt), .in_en(in_en),
    .in_op(in_op), .in_pc_reg(in_pc_reg), .in_imm_type_u(in_imm_type_u),
    .in_imm_type_j(in_imm_type_j), .in_imm_type_i(in_imm_type_i),
    .in_rs1_data(in_rs1_data), .in_rd(in_rd), .in_wb_ready(in_wb_ready),
    .out_waddr(out_waddr), .out_wen(out_wen), .out_wdata(out_wdata),
    .out_jump_en(out_jump_en), .out_jump_addr(out_jump_addr),
    .out_misalign(out_misalign), .out_busy(out_busy)
  );

  switch_mcu_alu_upper #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .in_clk(in_clk), .in_rst(in_rst), .in_cycle_cnt(in_cycle_cnt), .in_en(in_en),
    .in_op(in_op), .in_pc_reg({32'h0, in_pc_reg}), .in_imm_type_u(in_imm_type_u),
    .in_imm_type_j(in_imm_type_j), .in_imm_type_i(in_imm_type_i),
    .in_rs1_data({32'h0, in_rs1_data}), .in_rd(in_rd), .in_wb_ready(in_wb_ready),
    .out_waddr(w64_waddr), .out_wen(w64_wen), .out_wdata(w64_wdata),
    .out_jump_en(w64_jump_en), .out_jump_addr(w64_jump_addr),
    .out_misalign(w64_misalign), .out_busy(w64_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending writebacks as a plain queue, pulses as flags.
  typedef struct {
    int     addr;
    longint data;
  } ent_t;

  ent_t   mq[$];
  bit     m_jen;
  bit     m_mis;
  longint m_jaddr;

  localparam longint MASK = 64'hFFFF_FFFF;

  function automatic longint sext(input longint v, input int bits);
    if (((v >> (bits - 1)) & 1) != 0) return v - (longint'(1) << bits);
    return v;
  endfunction

  task automatic model_edge();
    longint pc, res, tgt;
    bit     jump, mis, acc;
    m_jen = 0; m_mis = 0; m_jaddr = 0;
    if (!in_rst) begin
      mq.delete();
      return;
    end
    acc = in_en && (in_cycle_cnt == 4'd1) && (mq.size() < DEPTH);
    if (mq.size() > 0 && in_wb_ready) void'(mq.pop_front());
    if (!acc) return;
    pc   = (longint'(in_pc_reg) - 4) & MASK;
    res  = (pc + 4) & MASK;
    tgt  = 0;
    jump = (in_op == OP_JAL) || (in_op == OP_JALR);
    case (in_op)
      OP_LUI:   res = sext(longint'(in_imm_type_u) << 12, 32) & MASK;
      OP_AUIPC: res = (pc + sext(longint'(in_imm_type_u) << 12, 32)) & MASK;
      OP_JAL:   tgt = (pc + sext(longint'(in_imm_type_j), 21)) & MASK;
      default:  tgt = ((longint'(in_rs1_data) + sext(longint'(in_imm_type_i), 12)) & MASK)
                      & ~longint'(1);
    endcase
    mis = jump && (((tgt >> 1) & 1) != 0);
    if (jump && !mis) begin m_jen = 1; m_jaddr = tgt; end
    if (mis) m_mis = 1;
    if (in_rd != 0 && !mis) mq.push_back('{addr: int'(in_rd), data: res});
  endtask

  // Advance one clock, then compare every output with the model.
  task automatic cycle();
    model_edge();
    @(posedge in_clk);
    #1;
    check("wen",   64'(out_wen),   64'(mq.size() > 0));
    check("waddr", 64'(out_waddr), (mq.size() > 0) ? 64'(mq[0].addr) : 64'd0);
    check("wdata", 64'(out_wdata), (mq.size() > 0) ? 64'(mq[0].data) : 64'd0);
    check("busy",  64'(out_busy),  64'(mq.size() == DEPTH));
    check("jump_en",  64'(out_jump_en),  64'(m_jen));
    check("misalign", 64'(out_misalign), 64'(m_mis));
    if (m_jen) check("jump_addr", 64'(out_jump_addr), 64'(m_jaddr));
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] pc, input logic [19:0] u,
                       input logic [20:0] j, input logic [11:0] i, input logic [31:0] rs1,
                       input logic [4:0] rd);
    in_en = 1'b1; in_cycle_cnt = 4'd1; in_op = op; in_pc_reg = pc;
    in_imm_type_u = u; in_imm_type_j = j; in_imm_type_i = i;
    in_rs1_data = rs1; in_rd = rd;
    cycle();
  endtask

  task automatic idle();
    in_en = 1'b0;
    cycle();
  endtask

  initial begin
    in_rst = 1'b0; in_cycle_cnt = 4'd0; in_en = 1'b0; in_op = 2'd0; in_pc_reg = '0;
    in_imm_type_u = '0; in_imm_type_j = '0; in_imm_type_i = '0; in_rs1_data = '0;
    in_rd = '0; in_wb_ready = 1'b1;
    cycle();
    cycle();
    in_rst = 1'b1;
    idle();

    // AUIPC
    issue(OP_AUIPC, 32'h0000_1004, 20'h12345, '0, '0, '0, 5'd5);
    check("auipc_data", 64'(out_wdata), 64'h1234_6000);
    check("auipc_addr", 64'(out_waddr), 64'd5);
    idle();
    check("auipc_drained", 64'(out_wen), 64'd0);

    // LUI, both widths
    issue(OP_LUI, 32'h0, 20'hFFFFF, '0, '0, '0, 5'd3);
    check("lui32", 64'(out_wdata), 64'hFFFF_F000);
    check("lui64", w64_wdata, 64'hFFFF_FFFF_FFFF_F000);
    idle();

    // JAL with negative offset
    issue(OP_JAL, 32'h2004, '0, 21'h1FFFF8, '0, '0, 5'd1);
    check("jal_en", 64'(out_jump_en), 64'd1);
    check("jal_addr", 64'(out_jump_addr), 64'h1FF8);
    check("jal_link", 64'(out_wdata), 64'h2004);
    idle();

    // JALR to x0: jump, no writeback
    issue(OP_JALR, 32'h0, '0, '0, 12'h004, 32'h3001, 5'd0);
    check("jalr_addr", 64'(out_jump_addr), 64'h3004);
    check("jalr_nowb", 64'(out_wen), 64'd0);
    idle();

    // Misaligned JALR
    issue(OP_JALR, 32'h0, '0, '0, 12'h000, 32'h3002, 5'd7);
    check("mis_pulse", 64'(out_misalign), 64'd1);
    check("mis_nojump", 64'(out_jump_en), 64'd0);
    check("mis_nowb", 64'(out_wen), 64'd0);
    idle();

    // Backpressure: third accept dropped while full
    in_wb_ready = 1'b0;
    issue(OP_LUI, 32'h0, 20'h00001, '0, '0, '0, 5'd1);
    issue(OP_LUI, 32'h0, 20'h00002, '0, '0, '0, 5'd2);
    check("bp_busy", 64'(out_busy), 64'd1);
    issue(OP_LUI, 32'h0, 20'h00003, '0, '0, '0, 5'd3);
    check("bp_head_hold", 64'(out_waddr), 64'd1);
    in_wb_ready = 1'b1;
    idle();
    check("bp_second", 64'(out_waddr), 64'd2);
    idle();
    check("bp_empty", 64'(out_wen), 64'd0);
    check("bp_notbusy", 64'(out_busy), 64'd0);

    // Reset with a full queue
    in_wb_ready = 1'b0;
    issue(OP_AUIPC, 32'h100, 20'h00010, '0, '0, '0, 5'd9);
    issue(OP_JAL, 32'h104, '0, 21'h000010, '0, '0, 5'd10);
    in_en = 1'b0; in_rst = 1'b0;
    cycle();
    check("rst_wen", 64'(out_wen), 64'd0);
    check("rst_jump", 64'(out_jump_en), 64'd0);
    in_rst = 1'b1; in_wb_ready = 1'b1;
    idle();
    idle();
    check("rst_nodrain", 64'(out_wen), 64'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      in_rst        = ($urandom_range(0, 99) != 0);
      in_en         = ($urandom_range(0, 2) != 0);
      in_cycle_cnt  = 4'($urandom_range(0, 2));
      in_op         = 2'($urandom_range(0, 3));
      in_pc_reg     = $urandom;
      in_imm_type_u = 20'($urandom);
      in_imm_type_j = 21'($urandom);
      in_imm_type_i = 12'($urandom);
      in_rs1_data   = $urandom;
      in_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_wb_ready   = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_mcu_alu_upper.md
# switch_mcu_alu_upper

Upper-immediate and jump execution unit for the switch MCU core. It executes LUI, AUIPC, JAL and JALR, and produces register writebacks and jump redirects. It sits beside the other `switch_mcu_alu_*` units behind the decoder. It adds generalised width and a buffered valid/ready writeback port with stall feedback to the decoder.

## Interface
Parameters:
- `XLEN`, 32: datapath width, at least 32.
- `DEPTH`, 2: writeback queue entries, at least 1.
- `ISSUE_CYCLE`, 1: value of `in_cycle_cnt` on which an instruction is accepted.
- `PC_OFFSET`, 4: amount by which `in_pc_reg` is already advanced past the current instruction.

Ports:
- `in_clk` input 1: clock. Single clock domain.
- `in_rst` input 1: reset, synchronous, active-low.
- `in_cycle_cnt` input 4: decoder cycle counter.
- `in_en` input 1: unit selected by the decoder.
- `in_op` input 2: operation. 0 = LUI, 1 = AUIPC, 2 = JAL, 3 = JALR.
- `in_pc_reg` input XLEN: fetch PC, already advanced by `PC_OFFSET`.
- `in_imm_type_u` input 20: U-immediate.
- `in_imm_type_j` input 21: J-immediate, bit 0 included.
- `in_imm_type_i` input 12: I-immediate.
- `in_rs1_data` input XLEN: rs1 operand, used by JALR.
- `in_rd` input 5: destination register.
- `in_wb_ready` input 1: register file accepts a writeback.
- `out_waddr` output 5: writeback address, taken from the queue head.
- `out_wen` output 1: writeback valid.
- `out_wdata` output XLEN: writeback data.
- `out_jump_en` output 1: one-cycle redirect pulse.
- `out_jump_addr` output XLEN: redirect target.
- `out_misalign` output 1: one-cycle pulse for an instruction-address-misaligned fault.
- `out_busy` output 1: queue full; the decoder must not issue.

## Operation
- **Accept condition:** `in_rst` high, `in_en` high, `in_cycle_cnt == ISSUE_CYCLE` and `out_busy` low. All inputs are sampled on that edge.
- **Current PC:** `pc = in_pc_reg - PC_OFFSET`, computed modulo 2^XLEN.
- **Immediates:**
  - `u = sext(in_imm_type_u << 12)` to XLEN.
  - `j = sext(in_imm_type_j)`.
  - `i = sext(in_imm_type_i)`.
- **LUI:** result = `u`.
- **AUIPC:** result = `pc + u`.
- **JAL:** target = `pc + j`; result (link) = `pc + 4`.
- **JALR:** target = `(in_rs1_data + i) & ~1`; result (link) = `pc + 4`.
- **Jump misalignment** (`target[1] == 1`):
  - `out_misalign` pulses.
  - No jump is issued and nothing is enqueued.
- **Jump aligned:** `out_jump_en` pulses with `out_jump_addr = target`.
- **Writeback enqueue:** `{in_rd, result}` is enqueued unless `in_rd == 0` or a misalignment fault occurred. For `rd == 0`, JAL/JALR still jump.
- **Queue:** FIFO of `DEPTH` entries.
  - `out_wen` = queue non-empty.
  - `out_waddr` and `out_wdata` = head entry; they are held stable while `out_wen && !in_wb_ready`.
  - Pop on `out_wen && in_wb_ready`.
  - When `out_wen` is low, `out_waddr` and `out_wdata` read 0.
- **`out_busy`:** `count == DEPTH`. There is no push-while-full, even when a pop occurs in the same cycle.
- **Simultaneous push and pop:** when not full, both happen and `count` is unchanged. When `count == 1`, the new entry becomes head on the next cycle.
- **Queue state:** `count` ranges 0..DEPTH; read/write pointers wrap modulo `DEPTH`.

## Timing
- **Reset:** while `in_rst` is low at a clock edge, every output is 0, count is 0 and pointers are 0. Reset mid-operation drops queued writebacks and any pending pulse.
- **Writeback latency:** accept at edge N with an empty queue gives `out_wen` high in cycle N+1. If the queue is non-empty, the entry waits behind earlier entries.
- **Redirect and fault latency:** `out_jump_en` and `out_misalign` are registered and high only in cycle N+1. They are independent of queue state.
- `out_busy` is registered from `count` and updates in the cycle after a push or pop.
- An `in_en` pulse on a cycle other than `ISSUE_CYCLE` has no effect.

## Structure
- **Shared package `switch_mcu_pkg`:**
  - opcode constants `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`;
  - default `PC_OFFSET`;
  - the writeback entry typedef `{waddr[4:0], wdata[XLEN-1:0]}`.
- **Sub-module `switch_mcu_wb_fifo`:** parametrised by width and `DEPTH`, providing push/pop, count, full and head outputs. The arithmetic and the pulse registers stay in the top level.

## Test plan
- **AUIPC:** `in_pc_reg` = 0x00001004, `in_imm_type_u` = 0x12345, `in_rd` = 5, ready high → next cycle `out_wen` = 1, `out_waddr` = 5, `out_wdata` = 0x12346000; the following cycle `out_wen` = 0.
- **LUI:** `in_imm_type_u` = 0xFFFFF, `in_rd` = 3, XLEN = 32 → `out_wdata` = 0xFFFFF000. With XLEN = 64 → 0xFFFFFFFFFFFFF000.
- **JAL and JALR:**
  - JAL: `in_pc_reg` = 0x2004, `in_imm_type_j` = 0x1FFFF8, `in_rd` = 1 → `out_jump_en` pulse with `out_jump_addr` = 0x1FF8 and writeback 0x2004.
  - JALR: `in_rs1_data` = 0x3001, `in_imm_type_i` = 0x004, `in_rd` = 0 → jump to 0x3004 and no writeback.
- **Misaligned JALR:** `in_rs1_data` = 0x3002, `in_imm_type_i` = 0 → `out_misalign` pulse, `out_jump_en` = 0, no writeback.
- **Backpressure:** DEPTH = 2, `in_wb_ready` low, three back-to-back accepts attempted → `out_busy` = 1 after the second, the third is ignored and the head is held stable. Raise ready → two entries drain in order in two cycles, then `out_busy` = 0.
- **Reset mid-operation:** queue holding 2 entries, `in_rst` low for one edge → all outputs 0 next cycle and nothing is drained afterwards.
